// File: rtl/proc_ctrl_pkg.sv
// Shared types and width helpers for the processor timestep controller.
package proc_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_LD   = 4'd0,
    OP_CP   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_INV  = 4'd4,
    OP_FLP  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_LSL  = 4'd9,
    OP_LSR  = 4'd10,
    OP_ASR  = 4'd11,
    OP_ADDI = 4'd12,
    OP_SUBI = 4'd13,
    OP_ILL0 = 4'd14,
    OP_ILL1 = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_e;

  function automatic int ridxW(input int numRegs);
    return $clog2(numRegs);
  endfunction

  // Immediate occupies everything below Rx, so it overlaps Ry.
  function automatic int immW(input int dataW, input int numRegs);
    return dataW - 4 - ridxW(numRegs);
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of the instruction register into opcode, register
// indices and immediate, plus opcode class flags.
module instr_field_decode
  import proc_ctrl_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int NUM_REGS = 4,
  localparam int RIDX_W  = ridxW(NUM_REGS),
  localparam int IMM_W   = immW(DATA_W, NUM_REGS)
) (
  input  logic [DATA_W-1:0] i_ir,
  output opcode_e           o_opcode,
  output logic [RIDX_W-1:0] o_rx,
  output logic [RIDX_W-1:0] o_ry,
  output logic [IMM_W-1:0]  o_imm,
  output logic              o_isIllegal,
  output logic              o_isImm,
  output logic              o_isAlu
);

  logic [3:0] w_opBits;

  assign w_opBits    = i_ir[DATA_W-1 -: 4];
  assign o_opcode    = opcode_e'(w_opBits);
  assign o_rx        = i_ir[DATA_W-5 -: RIDX_W];
  assign o_ry        = i_ir[DATA_W-5-RIDX_W -: RIDX_W];
  assign o_imm       = i_ir[IMM_W-1:0];
  assign o_isIllegal = (w_opBits >= 4'd14);
  assign o_isImm     = (w_opBits == 4'd12) || (w_opBits == 4'd13);
  assign o_isAlu     = (w_opBits >= 4'd2) && (w_opBits <= 4'd13);

endmodule

// File: rtl/proc_control_fsm.sv
// Clocked timestep controller: fetches an instruction under Run/Done,
// sequences register-file/ALU/bus enables and counts retired instructions.
module proc_control_fsm
  import proc_ctrl_pkg::*;
#(
  parameter int DATA_W   = 10,
  parameter int NUM_REGS = 4,
  parameter int CNT_W    = 16,
  localparam int RIDX_W  = ridxW(NUM_REGS),
  localparam int IMM_W   = immW(DATA_W, NUM_REGS)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic [DATA_W-1:0] i_externalData,
  output logic [DATA_W-1:0] o_immediateValue,
  output logic              o_immEnable,
  output logic [RIDX_W-1:0] o_registerToWrite,
  output logic [RIDX_W-1:0] o_registerToRead,
  output logic              o_writeEnable,
  output logic              o_readEnable,
  output logic              o_aluInputEnable,
  output logic              o_aluOutputEnable,
  output logic              o_aluToBusEnable,
  output logic [3:0]        o_aluControl,
  output logic              o_externalBusEnable,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_illegalOp,
  output logic [CNT_W-1:0]  o_instrCount
);

  state_e            r_state;
  logic [DATA_W-1:0] r_ir;
  logic [CNT_W-1:0]  r_instrCount;

  opcode_e           w_opcode;
  logic [RIDX_W-1:0] w_rx;
  logic [RIDX_W-1:0] w_ry;
  logic [IMM_W-1:0]  w_imm;
  logic              w_isIllegal;
  logic              w_isImm;
  logic              w_isAlu;

  instr_field_decode #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_decode (
    .i_ir        (r_ir),
    .o_opcode    (w_opcode),
    .o_rx        (w_rx),
    .o_ry        (w_ry),
    .o_imm       (w_imm),
    .o_isIllegal (w_isIllegal),
    .o_isImm     (w_isImm),
    .o_isAlu     (w_isAlu)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_ir         <= '0;
      r_instrCount <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_ir    <= i_externalData;
            r_state <= S_T1;
          end
        end
        S_T1: begin
          if (w_isAlu) begin
            r_state <= S_T2;
          end else begin
            r_state <= S_IDLE;
            if (!w_isIllegal) r_instrCount <= r_instrCount + CNT_W'(1);
          end
        end
        S_T2: r_state <= S_T3;
        S_T3: begin
          r_state      <= S_IDLE;
          r_instrCount <= r_instrCount + CNT_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset gates every strobe so an aborted instruction can never write.
  always_comb begin
    o_immediateValue    = '0;
    o_immEnable         = 1'b0;
    o_registerToWrite   = '0;
    o_registerToRead    = '0;
    o_writeEnable       = 1'b0;
    o_readEnable        = 1'b0;
    o_aluInputEnable    = 1'b0;
    o_aluOutputEnable   = 1'b0;
    o_aluToBusEnable    = 1'b0;
    o_aluControl        = 4'd0;
    o_externalBusEnable = 1'b0;
    o_busy              = 1'b0;
    o_done              = 1'b0;
    o_illegalOp         = 1'b0;
    if (!i_reset) begin
      o_busy = (r_state != S_IDLE);
      case (r_state)
        S_IDLE: o_externalBusEnable = i_run;
        S_T1: begin
          if (w_isIllegal) begin
            o_illegalOp = 1'b1;
            o_done      = 1'b1;
          end else if (w_opcode == OP_LD) begin
            o_externalBusEnable = 1'b1;
            o_writeEnable       = 1'b1;
            o_registerToWrite   = w_rx;
            o_done              = 1'b1;
          end else if (w_opcode == OP_CP) begin
            o_readEnable      = 1'b1;
            o_registerToRead  = w_ry;
            o_writeEnable     = 1'b1;
            o_registerToWrite = w_rx;
            o_done            = 1'b1;
          end else begin
            o_readEnable     = 1'b1;
            o_registerToRead = w_rx;
            o_aluInputEnable = 1'b1;
          end
        end
        S_T2: begin
          o_aluOutputEnable = 1'b1;
          if (w_isImm) begin
            o_immEnable      = 1'b1;
            o_immediateValue = {{(DATA_W-IMM_W){1'b0}}, w_imm};
            o_aluControl     = (w_opcode == OP_ADDI) ? 4'(OP_ADD) : 4'(OP_SUB);
          end else begin
            o_readEnable     = 1'b1;
            o_registerToRead = w_ry;
            o_aluControl     = w_opcode;
          end
        end
        S_T3: begin
          o_aluToBusEnable  = 1'b1;
          o_writeEnable     = 1'b1;
          o_registerToWrite = w_rx;
          o_done            = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_instrCount = r_instrCount;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Self-checking bench: per-cycle vector table on the default configuration,
// plus a hand-written sequence on a 12-bit/8-register/2-bit-counter variant.
module tb_proc_control_fsm;

  localparam logic [9:0] BUSY = 10'b1000000000;
  localparam logic [9:0] DONE = 10'b0100000000;
  localparam logic [9:0] ILL  = 10'b0010000000;
  localparam logic [9:0] EBE  = 10'b0001000000;
  localparam logic [9:0] IMME = 10'b0000100000;
  localparam logic [9:0] WE   = 10'b0000010000;
  localparam logic [9:0] RE   = 10'b0000001000;
  localparam logic [9:0] AIE  = 10'b0000000100;
  localparam logic [9:0] AOE  = 10'b0000000010;
  localparam logic [9:0] ATB  = 10'b0000000001;

  typedef struct {
    logic        rst;
    logic        run;
    logic [9:0]  ext;
    logic [9:0]  flags;
    logic [1:0]  wIdx;
    logic [1:0]  rIdx;
    logic [3:0]  alu;
    logic [9:0]  imm;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset0, run0;
  logic [9:0]  ext0, immVal0;
  logic        immEn0, we0, re0, aie0, aoe0, atb0, ebe0, busy0, done0, ill0;
  logic [1:0]  wIdx0, rIdx0;
  logic [3:0]  alu0;
  logic [15:0] cnt0;

  logic        reset1, run1;
  logic [11:0] ext1, immVal1;
  logic        immEn1, we1, re1, aie1, aoe1, atb1, ebe1, busy1, done1, ill1;
  logic [2:0]  wIdx1, rIdx1;
  logic [3:0]  alu1;
  logic [1:0]  cnt1;

  proc_control_fsm dut0 (
    .i_clock (clock), .i_reset (reset0), .i_run (run0), .i_externalData (ext0),
    .o_immediateValue (immVal0), .o_immEnable (immEn0),
    .o_registerToWrite (wIdx0), .o_registerToRead (rIdx0),
    .o_writeEnable (we0), .o_readEnable (re0),
    .o_aluInputEnable (aie0), .o_aluOutputEnable (aoe0), .o_aluToBusEnable (atb0),
    .o_aluControl (alu0), .o_externalBusEnable (ebe0),
    .o_busy (busy0), .o_done (done0), .o_illegalOp (ill0), .o_instrCount (cnt0)
  );

  proc_control_fsm #(.DATA_W(12), .NUM_REGS(8), .CNT_W(2)) dut1 (
    .i_clock (clock), .i_reset (reset1), .i_run (run1), .i_externalData (ext1),
    .o_immediateValue (immVal1), .o_immEnable (immEn1),
    .o_registerToWrite (wIdx1), .o_registerToRead (rIdx1),
    .o_writeEnable (we1), .o_readEnable (re1),
    .o_aluInputEnable (aie1), .o_aluOutputEnable (aoe1), .o_aluToBusEnable (atb1),
    .o_aluControl (alu1), .o_externalBusEnable (ebe1),
    .o_busy (busy1), .o_done (done1), .o_illegalOp (ill1), .o_instrCount (cnt1)
  );

  function automatic logic [9:0] flags0();
    return {busy0, done0, ill0, ebe0, immEn0, we0, re0, aie0, aoe0, atb0};
  endfunction

  function automatic logic [9:0] flags1();
    return {busy1, done1, ill1, ebe1, immEn1, we1, re1, aie1, aoe1, atb1};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic rst, input logic run, input logic [9:0] ext,
                                 input logic [9:0] flags, input logic [1:0] w, input logic [1:0] r,
                                 input logic [3:0] alu, input logic [9:0] imm, input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.run = run; v.ext = ext; v.flags = flags;
    v.wIdx = w; v.rIdx = r; v.alu = alu; v.imm = imm; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic rst, input logic run, input logic [11:0] ext);
    @(negedge clock);
    reset1 = rst;
    run1   = run;
    ext1   = ext;
    #1;
  endtask

  localparam logic [9:0] LD2  = 10'b0000_10_0000;
  localparam logic [9:0] LD1  = 10'b0000_01_0000;
  localparam logic [9:0] ADDI = 10'b1100_01_0101;
  localparam logic [9:0] ILLW = 10'b1111_00_0000;
  localparam logic [9:0] CP31 = 10'b0001_11_0100;
  localparam logic [9:0] ADD  = 10'b0010_11_0100;
  localparam logic [9:0] SUB  = 10'b0011_10_0111;
  localparam logic [11:0] SUBI12 = 12'b1101_110_00011;
  localparam logic [11:0] LD12   = 12'b0000_101_00000;

  initial begin
    reset0 = 1'b1; run0 = 1'b0; ext0 = '0;
    reset1 = 1'b1; run1 = 1'b0; ext1 = '0;
    @(posedge clock);

    // reset wins over Run, then LD r2
    addVec(1, 1, LD2,  10'b0,          0, 0, 0, 0, 0);
    addVec(0, 0, LD2,  10'b0,          0, 0, 0, 0, 0);
    addVec(0, 1, LD2,  EBE,            0, 0, 0, 0, 0);
    addVec(0, 0, 10'h3FF, BUSY|DONE|EBE|WE, 2, 0, 0, 0, 0);
    addVec(0, 0, 10'h0, 10'b0,         0, 0, 0, 0, 1);
    // ADDI r1,#5 with Run pulses while busy
    addVec(0, 1, ADDI, EBE,            0, 0, 0, 0, 1);
    addVec(0, 1, LD2,  BUSY|RE|AIE,    0, 1, 0, 0, 1);
    addVec(0, 1, LD2,  BUSY|IMME|AOE,  0, 0, 2, 5, 1);
    addVec(0, 0, LD2,  BUSY|ATB|WE|DONE, 1, 0, 0, 0, 1);
    addVec(0, 0, LD2,  10'b0,          0, 0, 0, 0, 2);
    // illegal opcode
    addVec(0, 1, ILLW, EBE,            0, 0, 0, 0, 2);
    addVec(0, 0, LD2,  BUSY|DONE|ILL,  0, 0, 0, 0, 2);
    addVec(0, 0, LD2,  10'b0,          0, 0, 0, 0, 2);
    // CP r3 <- r1
    addVec(0, 1, CP31, EBE,            0, 0, 0, 0, 2);
    addVec(0, 0, LD2,  BUSY|DONE|RE|WE, 3, 1, 0, 0, 2);
    // ADD aborted by reset in T2
    addVec(0, 1, ADD,  EBE,            0, 0, 0, 0, 3);
    addVec(0, 0, LD2,  BUSY|RE|AIE,    0, 3, 0, 0, 3);
    addVec(1, 0, LD2,  10'b0,          0, 0, 0, 0, 3);
    addVec(0, 0, LD2,  10'b0,          0, 0, 0, 0, 0);
    addVec(0, 0, LD2,  10'b0,          0, 0, 0, 0, 0);
    // back-to-back LD r1 then SUB r2,r1 with Run held high
    addVec(0, 1, LD1,  EBE,            0, 0, 0, 0, 0);
    addVec(0, 1, SUB,  BUSY|DONE|EBE|WE, 1, 0, 0, 0, 0);
    addVec(0, 1, SUB,  EBE,            0, 0, 0, 0, 1);
    addVec(0, 1, LD2,  BUSY|RE|AIE,    0, 2, 0, 0, 1);
    addVec(0, 0, LD2,  BUSY|RE|AOE,    0, 1, 3, 0, 1);
    addVec(0, 1, LD2,  BUSY|ATB|WE|DONE, 2, 0, 0, 0, 1);
    addVec(0, 0, LD2,  10'b0,          0, 0, 0, 0, 2);

    foreach (vecs[i]) begin
      @(negedge clock);
      reset0 = vecs[i].rst;
      run0   = vecs[i].run;
      ext0   = vecs[i].ext;
      #1;
      checkOutput($sformatf("v%0d flags", i), 32'(flags0()),  32'(vecs[i].flags));
      checkOutput($sformatf("v%0d wIdx", i),  32'(wIdx0),     32'(vecs[i].wIdx));
      checkOutput($sformatf("v%0d rIdx", i),  32'(rIdx0),     32'(vecs[i].rIdx));
      checkOutput($sformatf("v%0d alu", i),   32'(alu0),      32'(vecs[i].alu));
      checkOutput($sformatf("v%0d imm", i),   32'(immVal0),   32'(vecs[i].imm));
      checkOutput($sformatf("v%0d count", i), 32'(cnt0),      32'(vecs[i].cnt));
    end

    // 12-bit / 8-register variant: SUBI r6,#3 then four LDs, counter wraps
    applyStimulus(1, 0, 12'h0);
    checkOutput("w12 reset flags", 32'(flags1()), 32'(10'b0));
    applyStimulus(0, 1, SUBI12);
    checkOutput("w12 fetch flags", 32'(flags1()), 32'(EBE));
    checkOutput("w12 reset count", 32'(cnt1), 32'd0);
    applyStimulus(0, 0, 12'h0);
    checkOutput("w12 T1 flags", 32'(flags1()), 32'(BUSY|RE|AIE));
    checkOutput("w12 T1 rIdx", 32'(rIdx1), 32'd6);
    applyStimulus(0, 0, 12'h0);
    checkOutput("w12 T2 flags", 32'(flags1()), 32'(BUSY|IMME|AOE));
    checkOutput("w12 T2 imm", 32'(immVal1), 32'd3);
    checkOutput("w12 T2 alu", 32'(alu1), 32'd3);
    applyStimulus(0, 0, 12'h0);
    checkOutput("w12 T3 flags", 32'(flags1()), 32'(BUSY|ATB|WE|DONE));
    checkOutput("w12 T3 wIdx", 32'(wIdx1), 32'd6);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, LD12);
      checkOutput($sformatf("w12 ld%0d idle count", i), 32'(cnt1), 32'((1 + i) % 4));
      checkOutput($sformatf("w12 ld%0d fetch", i), 32'(flags1()), 32'(EBE));
      applyStimulus(0, 1, LD12);
      checkOutput($sformatf("w12 ld%0d T1 flags", i), 32'(flags1()), 32'(BUSY|DONE|EBE|WE));
      checkOutput($sformatf("w12 ld%0d T1 wIdx", i), 32'(wIdx1), 32'd5);
    end
    applyStimulus(0, 0, 12'h0);
    checkOutput("w12 wrap count", 32'(cnt1), 32'd1);
    checkOutput("w12 final flags", 32'(flags1()), 32'(10'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
